branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters for the pipelined CPU. Sits beside the PC register in IF: given the fetch PC it returns the predicted next PC in the same cycle. EX writes the resolved branch outcome back into it, and it raises a mispredict/redirect so the pipeline flushes only on a wrong guess, not on every taken branch. It also keeps branch and mispredict performance counters.

## Interface
- PC_W, 16: PC and target width (bits); bit 0 always zero.
- ENTRIES, 16: BTB depth; power of 2, 2..256. IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, 1..4.
- PERF_W, 16: performance counter width.

- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  PC_W  current fetch PC.
- next_pc  out  PC_W  predicted next fetch PC (target if predicted taken, else if_pc+2).
- pred_taken  out  1  prediction for if_pc; carried down the pipe with the instruction.
- pred_hit  out  1  valid tag match for if_pc.
- ex_valid  in  1  EX holds a live (non-bubble) instruction.
- ex_is_branch  in  1  EX instruction is B or BR.
- ex_pc  in  PC_W  PC of the EX instruction.
- ex_taken  in  1  resolved direction.
- ex_target  in  PC_W  resolved target (PC+2+(imm<<1), or register for BR).
- ex_pred_taken  in  1  pred_taken value piped from IF.
- ex_pred_target  in  PC_W  next_pc value piped from IF.
- mispredict  out  1  EX branch prediction was wrong; flush IF/ID and ID/EX.
- redirect_pc  out  PC_W  correct next PC when mispredict=1 (ex_target if taken, else ex_pc+2).
- flush_tbl  in  1  synchronous clear of all BTB entries.
- stall  in  1  pipeline stall; suppresses updates and perf counting.
- branch_cnt  out  PERF_W  resolved branches.
- mispred_cnt  out  PERF_W  mispredicted branches.

## Operation
- Entry i: valid, tag = pc[PC_W-1:IDX_W+1], target[PC_W], ctr[CTR_W]. Index = pc[IDX_W:1].
- Lookup (combinational): hit = valid[idx] & tag match. pred_taken = hit & ctr[idx] MSB. next_pc = pred_taken ? target[idx] : if_pc+2, with PC+2 mod 2^PC_W (wraps).
- Resolve is live when upd = ex_valid & ex_is_branch & ~stall.
- mispredict = upd & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target)). It is combinational and 0 whenever upd=0.
- Update on clk edge when upd:
  - Hit at ex_pc: ctr saturating +1 if taken, -1 if not; target <= ex_target if taken.
  - Miss and taken: allocate/replace. valid=1, tag, target=ex_target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no change.
- flush_tbl: all valid <= 0 and all ctr <= 2^(CTR_W-1)-1. It takes priority over a same-cycle update. Perf counters are unaffected.
- Perf: branch_cnt += 1 per upd; mispred_cnt += 1 per mispredict. Both saturate at all-ones, no wrap.
- Unused inputs while ex_valid=0 are don't-care. X on them must not reach state.

## Timing
- Lookup latency 0 cycles (same-cycle next_pc). Update visible to lookup the cycle after the edge.
- Same-cycle lookup and update of the same index: lookup returns the pre-update entry (no bypass).
- Reset (async, rst_n=0): all valid=0, ctr = 2^(CTR_W-1)-1, branch_cnt=0, mispred_cnt=0. Outputs during reset: pred_hit=0, pred_taken=0, next_pc=if_pc+2, mispredict=0.
- Reset deasserted mid-operation: state starts clean on the first edge after release. Any in-flight EX branch resolves as a miss.
- stall=1: no table, perf, or mispredict activity; the lookup remains combinationally live.

## Test plan
- Reset then lookup 0x0010 -> pred_hit=0, pred_taken=0, next_pc=0x0012. Both perf counters 0.
- Resolve taken branch ex_pc=0x0010, ex_target=0x0040, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x0040, branch_cnt=1, mispred_cnt=1. Next cycle, lookup 0x0010 -> hit, pred_taken=1, next_pc=0x0040.
- Same branch resolved not-taken twice (CTR_W=2: 10->01->00) -> first resolve gives mispredict=1 and redirect_pc=0x0012. Lookup then pred_taken=0 with pred_hit=1. Three taken resolves saturate ctr at 11, and a fourth leaves it at 11.
- Aliasing, ENTRIES=16: allocate 0x0010, then taken at 0x0030 (same index, different tag) -> entry replaced. Lookup 0x0010 then misses.
- BR with changed register target: hit, predicted 0x0040, resolved 0x0080 -> mispredict=1, redirect_pc=0x0080, stored target becomes 0x0080.
- Edge cases:
  - flush_tbl and upd in the same cycle -> table empty afterwards.
  - if_pc=0xFFFE with no hit -> next_pc=0x0000.
  - stall=1 during resolve -> no counter changes.
  - Drive mispredicts until mispred_cnt=0xFFFF -> it holds at 0xFFFF.
  - Assert rst_n mid-run -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/branch_predictor.sv
`timescale 1ns/1ps
// Branch target buffer with saturating direction counters.
// Same-cycle lookup for IF, resolve/update from EX, perf counters.
module branch_predictor #(
  parameter int PC_W    = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   next_pc,
  output logic              pred_taken,
  output logic              pred_hit,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  input  logic              flush_tbl,
  input  logic              stall,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 1;

  localparam logic [CTR_W-1:0] CTR_WT =
    CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WN =
    CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [PC_W-1:0] PC_INC = PC_W'(2);

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_d   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_d   [ENTRIES];

  logic [PERF_W-1:0] branch_cnt_q;
  logic [PERF_W-1:0] branch_cnt_d;
  logic [PERF_W-1:0] mispred_cnt_q;
  logic [PERF_W-1:0] mispred_cnt_d;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             upd;

  assign rd_idx = if_pc[IDX_W:1];
  assign rd_tag = if_pc[PC_W-1:IDX_W+1];
  assign wr_idx = ex_pc[IDX_W:1];
  assign wr_tag = ex_pc[PC_W-1:IDX_W+1];

  // A branch held in reset never resolves, so gate with rst_n.
  assign upd = rst_n & ex_valid & ex_is_branch & ~stall;

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Combinational lookup for the fetch PC
  always_comb begin
    pred_hit   = rst_n && valid_q[rd_idx] &&
                 (tag_q[rd_idx] == rd_tag);
    pred_taken = pred_hit && ctr_q[rd_idx][CTR_W-1];
    next_pc    = pred_taken ? tgt_q[rd_idx] : if_pc + PC_INC;
  end

  // Resolve check against what IF guessed
  always_comb begin
    mispredict  = upd &&
                  ((ex_taken != ex_pred_taken) ||
                   (ex_taken && (ex_target != ex_pred_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + PC_INC;
  end

  // Table next state: flush wins over a same-cycle update
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (flush_tbl) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CTR_WN;
      end
    end else if (upd) begin
      if (wr_hit) begin
        if (ex_taken) begin
          tgt_d[wr_idx] = ex_target;
          if (ctr_q[wr_idx] != {CTR_W{1'b1}})
            ctr_d[wr_idx] = ctr_q[wr_idx] + CTR_W'(1);
        end else if (ctr_q[wr_idx] != '0) begin
          ctr_d[wr_idx] = ctr_q[wr_idx] - CTR_W'(1);
        end
      end else if (ex_taken) begin
        valid_d[wr_idx] = 1'b1;
        tag_d[wr_idx]   = wr_tag;
        tgt_d[wr_idx]   = ex_target;
        ctr_d[wr_idx]   = CTR_WT;
      end
    end
  end

  // Saturating perf counters
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd && (branch_cnt_q != {PERF_W{1'b1}}))
      branch_cnt_d = branch_cnt_q + PERF_W'(1);
    if (mispredict && (mispred_cnt_q != {PERF_W{1'b1}}))
      mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
  end

  // Table state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WN;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
